seq_div_10by5: RTL and testbench



---
 rtl/seq_div_10by5.sv | 116 +++++++++++
 tb/tb_seq_div_10by5.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_10by5.sv
// Multi-cycle unsigned radix-2 restoring divider, 10-bit dividend by 5-bit divisor.
// Start/done handshake; a zero divisor reports all-ones quotient with div_by_zero.
module seq_div_10by5 #(
  parameter int N = 10,
  parameter int M = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [M-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [M-1:0] remainder_o,
  output logic         div_by_zero_o
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one restoring iteration per cycle, N cycles
  // ZERO  | divisor was zero, load saturated result
  // DONE  | done pulse; a new start may be accepted here
  typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_t;

  localparam int CW = $clog2(N);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [M:0]    rem_q;
  logic [N-1:0]  shq_q;
  logic [M-1:0]  dvs_q;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  quo_res_q;
  logic [M-1:0]  rem_res_q;
  logic          dz_q;

  logic [M:0]    rem_shift;
  logic          fits;
  logic [M:0]    rem_d;
  logic [N-1:0]  shq_d;

  // R' < 2*divisor always, so the M+1 bit subtraction cannot wrap
  always_comb begin
    rem_shift = {rem_q[M-1:0], shq_q[N-1]};
    fits      = (rem_shift >= {1'b0, dvs_q});
    rem_d     = fits ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
    shq_d     = {shq_q[N-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      shq_q     <= '0;
      dvs_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_res_q <= '0;
      rem_res_q <= '0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            dvs_q   <= divisor_i;
            shq_q   <= dividend_i;
            rem_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (divisor_i == '0) ? ZERO : CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          shq_q <= shq_d;
          if (cnt_q == CW'(N - 1)) begin
            quo_res_q <= shq_d;
            rem_res_q <= rem_d[M-1:0];
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ZERO: begin
          quo_res_q <= '1;
          rem_res_q <= '0;
          dz_q      <= 1'b1;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quo_res_q;
  assign remainder_o   = rem_res_q;
  assign div_by_zero_o = dz_q;

endmodule

// File: tb/tb_seq_div_10by5.sv
// Scoreboard bench for seq_div_10by5: expected results are queued at start and
// popped when done pulses; each scenario task checks its own results inline.
module tb_seq_div_10by5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [9:0] dividend_i;
  logic [4:0] divisor_i;
  logic       busy_o;
  logic       done_o;
  logic [9:0] quotient_o;
  logic [4:0] remainder_o;
  logic       div_by_zero_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] q;
    logic [4:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];

  seq_div_10by5 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 10'd1023; e.r = 5'd0; e.dz = 1'b1;
    end else begin
      e.q = 10'(a / b); e.r = 5'(a % b); e.dz = 1'b0;
    end
    return e;
  endfunction

  // called #1 after an edge; start is sampled on the next edge
  task automatic drive_start(input int a, input int b);
    dividend_i = 10'(a);
    divisor_i  = 5'(b);
    start_i    = 1'b1;
    sb.push_back(model(a, b));
  endtask

  task automatic accept();
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if (done_o) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dividend_i = 10'($urandom_range(1023));
      divisor_i  = 5'($urandom_range(31));
      @(posedge clk); #1;
    end
    checks++;
    if ({busy_o, done_o, quotient_o, remainder_o, div_by_zero_o} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
               busy_o, done_o, quotient_o, remainder_o, div_by_zero_o);
    end
    start_i = 1'b0;
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (busy_o || done_o) seen++;
      end
      checks++;
      if (seen != 0) begin
        errors++;
        $display("FAIL reset_idle got %0d busy/done cycles want 0", seen);
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    exp_t e;
    drive_start(1000, 7);
    accept();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL basic_busy got %b want 1", busy_o);
    end
    wait_done(20, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 10) begin
      errors++; $display("FAIL basic_latency got %0d want 10", lat);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL basic_busy_done got %b want 0", busy_o);
    end
    checks++;
    if ({quotient_o, remainder_o, div_by_zero_o} !== {e.q, e.r, e.dz} || e.q != 10'd142) begin
      errors++;
      $display("FAIL basic_1000_7 got q=%0d r=%0d dz=%b want q=142 r=6 dz=0",
               quotient_o, remainder_o, div_by_zero_o);
    end
    @(posedge clk); #1;
    checks++;
    if (done_o !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse got %b want 0", done_o);
    end
    drive_start(5, 9);
    accept();
    wait_done(20, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 10 || {quotient_o, remainder_o, div_by_zero_o} !== {e.q, e.r, e.dz}) begin
      errors++;
      $display("FAIL basic_5_9 got lat=%0d q=%0d r=%0d want lat=10 q=%0d r=%0d",
               lat, quotient_o, remainder_o, e.q, e.r);
    end
  endtask

  task automatic test_inverse();
    int lat;
    exp_t e;
    drive_start(1023, 31);
    accept();
    wait_done(20, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 10 || quotient_o !== 10'd33 || remainder_o !== 5'd0) begin
      errors++;
      $display("FAIL inv_1023_31 got lat=%0d q=%0d r=%0d want lat=10 q=33 r=0",
               lat, quotient_o, remainder_o);
    end
    drive_start(961, 31);
    accept();
    wait_done(20, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 10 || quotient_o !== 10'd31 || remainder_o !== 5'd0) begin
      errors++;
      $display("FAIL inv_961_31 got lat=%0d q=%0d r=%0d want lat=10 q=31 r=0",
               lat, quotient_o, remainder_o);
    end
    for (int a = 1; a <= 31; a++) begin
      for (int b = 1; b <= 31; b++) begin
        drive_start(a * b, b);
        accept();
        wait_done(20, lat);
        e = sb.pop_front();
        checks++;
        if (lat != 10 || quotient_o !== 10'(a) || remainder_o !== 5'd0 ||
            {quotient_o, remainder_o, div_by_zero_o} !== {e.q, e.r, e.dz}) begin
          errors++;
          $display("FAIL inv_sweep %0d/%0d got lat=%0d q=%0d r=%0d want lat=10 q=%0d r=0",
                   a * b, b, lat, quotient_o, remainder_o, a);
        end
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    exp_t e;
    drive_start(600, 0);
    accept();
    wait_done(20, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 1) begin
      errors++; $display("FAIL dz_latency got %0d want 1", lat);
    end
    checks++;
    if ({quotient_o, remainder_o, div_by_zero_o} !== {e.q, e.r, e.dz} || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL dz_result got q=%0d r=%0d dz=%b busy=%b want q=1023 r=0 dz=1 busy=0",
               quotient_o, remainder_o, div_by_zero_o, busy_o);
    end
    drive_start(100, 10);
    accept();
    wait_done(20, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 10 || {quotient_o, remainder_o, div_by_zero_o} !== {e.q, e.r, e.dz}) begin
      errors++;
      $display("FAIL dz_next_100_10 got lat=%0d q=%0d r=%0d dz=%b want lat=10 q=10 r=0 dz=0",
               lat, quotient_o, remainder_o, div_by_zero_o);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    int extra = 0;
    exp_t e;
    drive_start(1000, 7);
    accept();
    repeat (3) @(posedge clk);
    #1;
    dividend_i = 10'd50;
    divisor_i  = 5'd3;
    start_i    = 1'b1;
    accept();
    wait_done(20, lat);
    e = sb.pop_front();
    checks++;
    if (lat + 4 != 10 || {quotient_o, remainder_o, div_by_zero_o} !== {e.q, e.r, e.dz}) begin
      errors++;
      $display("FAIL busy_ignore got lat=%0d q=%0d r=%0d want lat=10 q=142 r=6",
               lat + 4, quotient_o, remainder_o);
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done_o || busy_o) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL busy_single_done got %0d extra busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones = 0;
    drive_start(1000, 7);
    accept();
    repeat (5) @(posedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({busy_o, done_o, quotient_o, remainder_o, div_by_zero_o} !== 18'd0) begin
      errors++;
      $display("FAIL midreset_outputs got busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
               busy_o, done_o, quotient_o, remainder_o, div_by_zero_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL midreset_no_done got %0d dones want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    exp_t e;
    drive_start(200, 13);
    accept();
    wait_done(20, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 10 || {quotient_o, remainder_o, div_by_zero_o} !== {e.q, e.r, e.dz}) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d q=%0d r=%0d want lat=10 q=15 r=5",
               lat, quotient_o, remainder_o);
    end
    drive_start(31, 2);
    accept();
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy_o, done_o);
    end
    wait_done(20, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 10 || {quotient_o, remainder_o, div_by_zero_o} !== {e.q, e.r, e.dz}) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d q=%0d r=%0d want lat=10 q=15 r=1",
               lat, quotient_o, remainder_o);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    #1;
    test_reset();
    test_basic();
    test_inverse();
    test_div_by_zero();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
